calib_pfd_offset_seq: RTL
=========================

Name: calib_pfd_offset_seq

Overview:
Sequencer for PFD offset calibration. It drives the sample averager's update strobe at a fixed 2**Navg window rate and reads back the averaged ADC value. It then steps a PFD offset code up or down, one LSB per measurement, until the average reaches the target, the step direction reverses, or the code saturates. It sits between the averager and the PFD offset DAC control register.

Parameters:
Nadc, 8, width of signed average input/target
Nrange, 4, width of Navg (window = 2**Navg samples)
Noff, 8, width of unsigned offset code
Nsettle, 4, width of settle-window count

Ports:
clk  in  1  sample clock, same clock as averager
rstb  in  1  reset, asynchronous, active-low
en  in  1  level run request; low aborts to IDLE
Navg  in  Nrange  log2 window length
settle_win  in  Nsettle  windows discarded after each code change (0 treated as 1)
pol  in  1  0: err>0 decrements code; 1: err>0 increments code
target  in  signed Nadc  desired average
off_init  in  Noff  start code
avg_in  in  signed Nadc  averager avg_out
update  out  1  window strobe to averager
offset_code  out  Noff  PFD offset code
busy  out  1  high in SETTLE/EVAL
done  out  1  high in DONE
sat  out  1  code hit limit (valid with done)

Behaviour:
- Reset values: update=0, offset_code=0, busy=0, done=0, sat=0, window counter=0, state=IDLE.
- Window timer:
  - Free-running from reset regardless of en.
  - Counter width 2**Nrange bits. update=1 for exactly one cycle when counter==2**Navg-1, then counter wraps to 0.
  - Navg=0 gives update every cycle.
  - Navg is sampled only at wrap; a mid-window change applies from the next window.
- eval strobe: update delayed one cycle (avg_in valid). Used internally only.
- err = avg_in - target, computed in Nadc+1 signed bits (no overflow).
- step = sign(err) mapped through pol: +1, -1, or 0 when err==0.
- States:
  - IDLE: busy=0, done=0. Code held. If en=1, next cycle load offset_code=off_init, sat=0, clear last_dir, discard_cnt=max(settle_win,1), go SETTLE.
  - SETTLE: on each eval strobe decrement discard_cnt; when it reaches 0, go EVAL.
  - EVAL: on next eval strobe, evaluate step, in priority order:
    - step==0 -> DONE, code unchanged.
    - last_dir valid and step opposite last_dir (reversal) -> DONE, code unchanged.
    - code==0 with step -1, or code==2**Noff-1 with step +1 -> sat=1, DONE, code unchanged.
    - otherwise -> offset_code+=step (registered, changes the cycle after the strobe), last_dir=step, reload discard_cnt, go SETTLE.
  - DONE: done=1, code held. Stay while en=1. en=0 -> IDLE (done falls next cycle).
- en=0 in any state: IDLE next cycle; offset_code and sat hold, done/busy fall.
- Re-raising en always restarts from off_init.
- Termination is guaranteed within 2**Noff steps.
- rstb low mid-operation: all outputs to reset values immediately (asynchronous).
- settle_win is sampled at each reload only.

Decomposition:
- Shared package calib_pfd_offset_pkg holds:
  - state enum {IDLE, SETTLE, EVAL, DONE}
  - step/direction encoding constants (DIR_NONE, DIR_UP, DIR_DN)
- One sub-module, calib_window_timer: counter, Navg sampling at wrap, update and eval strobe generation.
- FSM and code arithmetic stay in the top.

Test Plan:
1. Navg=2 after reset, en=0 -> update high 1 cycle in 4, first on 4th clk edge. Navg 2->0 mid-window -> old period completes, then update every cycle.
2. Bench avg_in=code-40, target=0, pol=0, off_init=36, settle_win=1 -> codes 36,37,38,39,40; done=1, sat=0, offset_code=40 after 4 steps; busy high throughout.
3. avg_in=2*(code-40)+1, off_init=36 -> steps to 40. At 40 err=+1 requests down, reversal -> done, offset_code=40, sat=0.
4. avg_in=-100 constant, off_init=250, Noff=8 -> codes 251..255, then sat=1, done=1, offset_code=255. With pol=1 and off_init=3 -> 0, sat=1.
5. settle_win=3, Navg=1 -> exactly 3 eval strobes discarded between code changes; changes spaced 8 cycles. settle_win=0 behaves as 1.
6. Abort and reset:
   - en dropped in SETTLE at code 38 -> IDLE next cycle, busy=0, code stays 38. Re-raise -> code=off_init.
   - rstb pulsed mid-EVAL -> offset_code=0, update=0, done=0 immediately.

Source files
------------

// File: rtl/calib_pfd_offset_pkg.sv
// Shared types for the PFD offset calibration sequencer: FSM states and
// the encoding used for a code step and for the last step direction.
package calib_pfd_offset_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    EVAL   = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DN   = 2'd2;

endpackage

// File: rtl/calib_window_timer.sv
// Free-running averaging-window timer: emits a one-cycle update strobe every
// 2**navg cycles and an eval strobe one cycle later, when avg_in is valid.
module calib_window_timer #(
  parameter int Nrange = 4
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [Nrange-1:0] i_navg,
  output logic              o_update,
  output logic              o_eval
);

  localparam int CW = 2**Nrange;

  logic [CW-1:0]     r_cnt;
  logic [Nrange-1:0] r_navg;
  logic              r_update;
  logic              r_eval;

  logic [Nrange-1:0] w_navg;
  logic [CW-1:0]     w_term;
  logic              w_wrap;

  // A count of zero marks a window start: the live navg is taken there and
  // held for the rest of the window, so mid-window changes wait for the wrap.
  assign w_navg = (r_cnt == '0) ? i_navg : r_navg;
  assign w_term = (CW'(1) << w_navg) - CW'(1);
  assign w_wrap = (r_cnt == w_term);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_cnt    <= '0;
      r_navg   <= '0;
      r_update <= 1'b0;
      r_eval   <= 1'b0;
    end else begin
      r_cnt    <= w_wrap ? '0 : r_cnt + CW'(1);
      r_navg   <= w_navg;
      r_update <= w_wrap;
      r_eval   <= r_update;
    end
  end

  assign o_update = r_update;
  assign o_eval   = r_eval;

endmodule

// File: rtl/calib_pfd_offset_seq.sv
// PFD offset calibration sequencer: walks the offset code one LSB per
// measurement until the averaged error is zero, reverses, or saturates.
module calib_pfd_offset_seq
  import calib_pfd_offset_pkg::*;
#(
  parameter int Nadc    = 8,
  parameter int Nrange  = 4,
  parameter int Noff    = 8,
  parameter int Nsettle = 4
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   en,
  input  logic [Nrange-1:0]      Navg,
  input  logic [Nsettle-1:0]     settle_win,
  input  logic                   pol,
  input  logic signed [Nadc-1:0] target,
  input  logic [Noff-1:0]        off_init,
  input  logic signed [Nadc-1:0] avg_in,
  output logic                   update,
  output logic [Noff-1:0]        offset_code,
  output logic                   busy,
  output logic                   done,
  output logic                   sat
);

  localparam logic [Noff-1:0] CODE_MAX = '1;

  state_e             r_state, w_state_next;
  logic [Noff-1:0]    r_code, w_code_next;
  logic               r_sat, w_sat_next;
  logic [1:0]         r_last_dir, w_last_dir_next;
  logic [Nsettle-1:0] r_discard, w_discard_next;

  logic               w_eval;
  logic [Nsettle-1:0] w_reload;
  logic [Nadc:0]      w_err;
  logic [1:0]         w_step;

  calib_window_timer #(
    .Nrange (Nrange)
  ) u_timer (
    .clk      (clk),
    .rstb     (rstb),
    .i_navg   (Navg),
    .o_update (update),
    .o_eval   (w_eval)
  );

  assign w_reload = (settle_win == '0) ? Nsettle'(1) : settle_win;

  // One extra bit keeps avg_in - target exact for every input pair.
  assign w_err = {avg_in[Nadc-1], avg_in} - {target[Nadc-1], target};

  // Negative error with pol=0 (or positive with pol=1) asks for a higher code.
  always_comb begin
    w_step = DIR_NONE;
    if (w_err != '0) begin
      w_step = (w_err[Nadc] ^ pol) ? DIR_UP : DIR_DN;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state    <= IDLE;
      r_code     <= '0;
      r_sat      <= 1'b0;
      r_last_dir <= DIR_NONE;
      r_discard  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_code     <= w_code_next;
      r_sat      <= w_sat_next;
      r_last_dir <= w_last_dir_next;
      r_discard  <= w_discard_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_code_next     = r_code;
    w_sat_next      = r_sat;
    w_last_dir_next = r_last_dir;
    w_discard_next  = r_discard;
    busy            = 1'b0;
    done            = 1'b0;

    case (r_state)
      IDLE: begin
        if (en) begin
          w_code_next     = off_init;
          w_sat_next      = 1'b0;
          w_last_dir_next = DIR_NONE;
          w_discard_next  = w_reload;
          w_state_next    = SETTLE;
        end
      end
      SETTLE: begin
        busy = 1'b1;
        if (w_eval) begin
          if (r_discard <= Nsettle'(1)) begin
            w_discard_next = '0;
            w_state_next   = EVAL;
          end else begin
            w_discard_next = r_discard - Nsettle'(1);
          end
        end
      end
      EVAL: begin
        busy = 1'b1;
        if (w_eval) begin
          if (w_step == DIR_NONE) begin
            w_state_next = DONE;
          end else if ((r_last_dir != DIR_NONE) && (w_step != r_last_dir)) begin
            w_state_next = DONE;
          end else if (((r_code == '0) && (w_step == DIR_DN)) ||
                       ((r_code == CODE_MAX) && (w_step == DIR_UP))) begin
            w_sat_next   = 1'b1;
            w_state_next = DONE;
          end else begin
            w_code_next     = (w_step == DIR_UP) ? r_code + Noff'(1) : r_code - Noff'(1);
            w_last_dir_next = w_step;
            w_discard_next  = w_reload;
            w_state_next    = SETTLE;
          end
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Abort freezes the code and saturation flag where they stand.
    if (!en) begin
      w_state_next    = IDLE;
      w_code_next     = r_code;
      w_sat_next      = r_sat;
      w_last_dir_next = r_last_dir;
      w_discard_next  = r_discard;
    end
  end

  assign offset_code = r_code;
  assign sat         = r_sat;

endmodule
